// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: shares the single synchronous data-RAM port between the
// core's EX-stage data access and an external burst master (DMA/debug).
// The core owns the port by default with zero-latency pass-through; the DMA
// master gets bursts when the core is idle. With ARB_STARVE_GUARD_EN defined,
// a starvation counter also forces a grant after STARVE_LIMIT blocked cycles.
module data_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_BURST    = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  input  logic              core_we_i,
  input  logic              core_re_i,
  input  logic [2:0]        core_size_i,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_hold_o,
  input  logic              dma_req_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  input  logic              dma_we_i,
  input  logic [2:0]        dma_size_i,
  input  logic              dma_last_i,
  output logic              dma_gnt_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              dma_rvalid_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_we_o,
  output logic              ram_re_o,
  output logic [2:0]        ram_size_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam int            BW       = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {S_CORE, S_DMA, S_COOL} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic          rvalid_q, rvalid_d;
  logic          core_acc;
  logic          force_gnt;

  assign core_acc = core_we_i | core_re_i;

  // Illegal parameter values elaborate this empty marker scope.
  if (MAX_BURST < 1 || STARVE_LIMIT < 1) begin : g_bad_params
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  assign force_gnt = (starve_cnt_q == STARVE_MAX);

  // Count S_CORE cycles where the DMA request loses to a core access; reaching
  // the limit forces the grant, which clears the count (so it never wraps).
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == S_CORE) begin
      if (!dma_req_i || !core_acc || force_gnt) starve_cnt_d = '0;
      else                                       starve_cnt_d = starve_cnt_q + SW'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_cnt_q <= '0;
    else      starve_cnt_q <= starve_cnt_d;
  end
`else
  // Without the guard the core always wins; DMA may wait forever.
  assign force_gnt = 1'b0;
`endif

  // Next-state and burst beat counting.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      S_CORE: begin
        if (dma_req_i && (!core_acc || force_gnt)) begin
          state_d    = S_DMA;
          beat_cnt_d = '0;
        end
      end
      S_DMA: begin
        if (!dma_req_i) begin
          state_d = S_COOL;
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          // Last beat and burst cap on the same beat collapse to one exit.
          if (dma_last_i || (beat_cnt_q + BW'(1)) == BEAT_MAX) state_d = S_COOL;
        end
      end
      S_COOL:  state_d = S_CORE;
      default: state_d = S_CORE;
    endcase
  end

  // DMA read data returns one cycle after the read beat.
  assign rvalid_d = (state_q == S_DMA) && dma_req_i && !dma_we_i;

  // State, beat count and read-valid registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_CORE;
      beat_cnt_q <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // RAM port mux: core pass-through unless DMA owns the port. A core access
  // seen during a DMA grant is held off; the core keeps it on its inputs.
  always_comb begin
    ram_addr_o  = core_addr_i;
    ram_wdata_o = core_wdata_i;
    ram_we_o    = core_we_i;
    ram_re_o    = core_re_i & ~core_we_i;
    ram_size_o  = core_size_i;
    dma_gnt_o   = 1'b0;
    core_hold_o = 1'b0;
    if (state_q == S_DMA) begin
      ram_addr_o  = dma_addr_i;
      ram_wdata_o = dma_wdata_i;
      ram_we_o    = dma_req_i & dma_we_i;
      ram_re_o    = dma_req_i & ~dma_we_i;
      ram_size_o  = dma_size_i;
      dma_gnt_o   = 1'b1;
      core_hold_o = core_acc;
    end
  end

  assign core_rdata_o = ram_rdata_i;
  assign dma_rdata_o  = ram_rdata_i;
  assign dma_rvalid_o = rvalid_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: core pass-through vectors, DMA write/read
// bursts checked through a scoreboard, starvation, burst cap, and resets.
module tb_data_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] core_addr_i, core_wdata_i;
  logic        core_we_i, core_re_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_rdata_o;
  logic        core_hold_o;
  logic        dma_req_i;
  logic [31:0] dma_addr_i, dma_wdata_i;
  logic        dma_we_i;
  logic [2:0]  dma_size_i;
  logic        dma_last_i;
  logic        dma_gnt_o;
  logic [31:0] dma_rdata_o;
  logic        dma_rvalid_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic        ram_we_o, ram_re_o;
  logic [2:0]  ram_size_o;
  logic [31:0] ram_rdata_i = '0;

  data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(16), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i), .core_we_i(core_we_i),
    .core_re_i(core_re_i), .core_size_i(core_size_i), .core_rdata_o(core_rdata_o),
    .core_hold_o(core_hold_o),
    .dma_req_i(dma_req_i), .dma_addr_i(dma_addr_i), .dma_wdata_i(dma_wdata_i),
    .dma_we_i(dma_we_i), .dma_size_i(dma_size_i), .dma_last_i(dma_last_i),
    .dma_gnt_o(dma_gnt_o), .dma_rdata_o(dma_rdata_o), .dma_rvalid_o(dma_rvalid_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o),
    .ram_re_o(ram_re_o), .ram_size_o(ram_size_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t         wq[$];
  logic [31:0] rq[$];
  wr_t         mon_w;
  logic [31:0] mon_r;
  int          we_pulses = 0;
  int          rv_pulses = 0;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == 32'h200) ? 32'hDEADBEEF : ~a;
  endfunction

  function automatic logic [31:0] wd_model(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Synchronous RAM read model: data one cycle after ram_re_o.
  always @(posedge clk) ram_rdata_i <= ram_re_o ? rd_model(ram_addr_o) : 32'h0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: compare every DMA write strobe and every DMA read return.
  always @(negedge clk) begin
    if (rst && dma_gnt_o && ram_we_o) begin
      we_pulses++;
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL dma_wr_unexpected: addr %0h with no pending beat", ram_addr_o);
      end else begin
        mon_w = wq.pop_front();
        chk("dma_wr_addr", ram_addr_o, mon_w.addr);
        chk("dma_wr_data", ram_wdata_o, mon_w.data);
      end
    end
    if (dma_rvalid_o) begin
      rv_pulses++;
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL dma_rd_unexpected: data %0h with no pending beat", dma_rdata_o);
      end else begin
        mon_r = rq.pop_front();
        chk("dma_rd_data", dma_rdata_o, mon_r);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents consecutive beats; a beat counts when the grant is seen with it.
  task automatic dma_burst(input int n, input logic [31:0] base, input logic we,
                           input bit use_last, output int beats, output int waits);
    logic [31:0] a;
    beats = 0; waits = 0;
    dma_req_i = 1'b1; dma_we_i = we;
    while (beats < n && waits < 64) begin
      a = base + 32'(4 * beats);
      dma_addr_i  = a;
      dma_wdata_i = wd_model(a);
      dma_last_i  = use_last && (beats == n - 1);
      #1;
      if (dma_gnt_o) begin
        if (we) wq.push_back('{addr: a, data: wd_model(a)});
        else    rq.push_back(rd_model(a));
        beats++;
      end else begin
        waits++;
      end
      tick();
    end
    dma_req_i = 1'b0; dma_last_i = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr; logic [31:0] wd; logic we; logic re; logic [2:0] sz;
    logic exp_we; logic exp_re;
  } vec_t;
  vec_t vecs[4];

  int beats, waits, first, run, gap, phase;

  initial begin
    vecs[0] = '{addr: 32'h10, wd: 32'h1111, we: 1'b0, re: 1'b0, sz: 3'd0, exp_we: 1'b0, exp_re: 1'b0};
    vecs[1] = '{addr: 32'h14, wd: 32'h2222, we: 1'b1, re: 1'b0, sz: 3'd2, exp_we: 1'b1, exp_re: 1'b0};
    vecs[2] = '{addr: 32'h18, wd: 32'h3333, we: 1'b0, re: 1'b1, sz: 3'd1, exp_we: 1'b0, exp_re: 1'b1};
    vecs[3] = '{addr: 32'h1C, wd: 32'h4444, we: 1'b1, re: 1'b1, sz: 3'd2, exp_we: 1'b1, exp_re: 1'b0};

    core_addr_i = 32'h40; core_wdata_i = '0; core_we_i = 0; core_re_i = 0; core_size_i = 3'd2;
    dma_req_i = 1'b1; dma_addr_i = '0; dma_wdata_i = '0; dma_we_i = 0; dma_size_i = 3'd2;
    dma_last_i = 0; rst = 1'b0;

    // Reset held with a pending DMA request.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_gnt", dma_gnt_o, 0);
      chk("rst_hold", core_hold_o, 0);
      chk("rst_rvalid", dma_rvalid_o, 0);
      chk("rst_ram_addr", ram_addr_o, 32'h40);
    end
    dma_req_i = 1'b0; rst = 1'b1;
    tick();

    // Core pass-through vectors.
    for (int i = 0; i < 4; i++) begin
      core_addr_i = vecs[i].addr; core_wdata_i = vecs[i].wd;
      core_we_i = vecs[i].we; core_re_i = vecs[i].re; core_size_i = vecs[i].sz;
      #1;
      chk("vec_addr", ram_addr_o, vecs[i].addr);
      chk("vec_wdata", ram_wdata_o, vecs[i].wd);
      chk("vec_size", ram_size_o, vecs[i].sz);
      chk("vec_we", ram_we_o, vecs[i].exp_we);
      chk("vec_re", ram_re_o, vecs[i].exp_re);
      chk("vec_gnt", dma_gnt_o, 0);
      tick();
    end
    core_we_i = 0; core_re_i = 0;
    tick();

    // DMA write burst, 4 beats, core idle.
    we_pulses = 0;
    dma_burst(4, 32'h100, 1'b1, 1'b1, beats, waits);
    #1;
    chk("wr_beats", beats, 4);
    chk("wr_gnt_latency", waits, 1);
    chk("wr_cool_gnt", dma_gnt_o, 0);
    chk("wr_pulses", we_pulses, 4);
    tick();

    // Single DMA read.
    rv_pulses = 0;
    dma_burst(1, 32'h200, 1'b0, 1'b1, beats, waits);
    #1;
    chk("rd_rvalid", dma_rvalid_o, 1);
    chk("rd_data", dma_rdata_o, 32'hDEADBEEF);
    tick();
    chk("rd_rvalid_drop", dma_rvalid_o, 0);
    chk("rd_pulses", rv_pulses, 1);

    // Four-beat read burst through the scoreboard.
    dma_burst(4, 32'h600, 1'b0, 1'b1, beats, waits);
    tick(); tick();
    chk("rd4_beats", beats, 4);
    chk("rd4_drained", rq.size(), 0);

    // Starvation: core reads every cycle while DMA requests.
    core_re_i = 1'b1; core_addr_i = 32'h300;
    dma_req_i = 1'b1; dma_we_i = 1'b1; dma_addr_i = 32'h500; dma_wdata_i = wd_model(32'h500);
    first = -1;
    for (int c = 0; c < 40 && first < 0; c++) begin
      #1;
      if (dma_gnt_o) first = c;
      else tick();
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("starve_gnt_cycle", first, 9);
    if (first >= 0) begin
      chk("starve_hold1", core_hold_o, 1);
      wq.push_back('{addr: 32'h500, data: wd_model(32'h500)});
      tick();
      dma_addr_i = 32'h504; dma_wdata_i = wd_model(32'h504); dma_last_i = 1'b1;
      #1;
      chk("starve_gnt2", dma_gnt_o, 1);
      chk("starve_hold2", core_hold_o, 1);
      wq.push_back('{addr: 32'h504, data: wd_model(32'h504)});
      tick();
      dma_req_i = 1'b0; dma_last_i = 1'b0;
      #1;
      chk("starve_cool_gnt", dma_gnt_o, 0);
      chk("starve_cool_re", ram_re_o, 1);
      chk("starve_cool_addr", ram_addr_o, 32'h300);
      chk("starve_cool_hold", core_hold_o, 0);
    end
`else
    chk("starve_no_gnt", first, -1);
`endif
    dma_req_i = 1'b0; dma_last_i = 1'b0; core_re_i = 1'b0;
    tick();

    // Reset during beat 3 of an 8-beat read burst.
    dma_req_i = 1'b1; dma_we_i = 1'b0; dma_addr_i = 32'h700;
    waits = 0;
    #1;
    while (!dma_gnt_o && waits < 20) begin tick(); waits++; #1; end
    chk("mid_gnt", dma_gnt_o, 1);
    rq.push_back(rd_model(32'h700));
    tick();
    dma_addr_i = 32'h704;
    tick();
    dma_addr_i = 32'h708; core_re_i = 1'b1; core_addr_i = 32'h44;
    #1;
    chk("mid_pre_hold", core_hold_o, 1);
    chk("mid_pre_rvalid", dma_rvalid_o, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_gnt", dma_gnt_o, 0);
    chk("mid_rst_hold", core_hold_o, 0);
    chk("mid_rst_rvalid", dma_rvalid_o, 0);
    chk("mid_rst_addr", ram_addr_o, 32'h44);
    tick();
    chk("mid_rst_gnt_held", dma_gnt_o, 0);
    core_re_i = 1'b0; dma_req_i = 1'b0; rst = 1'b1;
    tick();

    // Burst cap: no last beat, request held through the regrant.
    dma_req_i = 1'b1; dma_we_i = 1'b1; dma_last_i = 1'b0;
    run = 0; gap = 0; phase = 0;
    for (int c = 0; c < 60 && phase < 3; c++) begin
      dma_addr_i = 32'h800 + 32'(4 * run); dma_wdata_i = wd_model(dma_addr_i);
      #1;
      if (dma_gnt_o) begin
        wq.push_back('{addr: dma_addr_i, data: dma_wdata_i});
        if (phase == 2) phase = 3;
        else begin phase = 1; run++; end
      end else if (phase != 0) begin
        phase = 2; gap++;
      end
      tick();
    end
    dma_req_i = 1'b0;
    chk("cap_beats", run, 16);
    chk("cap_regrant_gap", gap, 2);
    tick(); tick();

    // Last beat coincides with the burst cap.
    dma_burst(16, 32'h900, 1'b1, 1'b1, beats, waits);
    #1;
    chk("cap_last_beats", beats, 16);
    chk("cap_last_cool", dma_gnt_o, 0);
    tick(); tick();

    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Shares the core's single synchronous data-RAM port between the pipeline's EX-stage data access (core master) and an external burst master (DMA/debug loader). It sits between the CPU core's data port and the RAM. The core keeps zero-latency access by default. The DMA master is granted bursts when the core is idle, or forcibly after a starvation limit. While the DMA master owns the port, the arbiter stalls the core through `core_hold_o`, which feeds the core's `hold_flag_i`.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MAX_BURST`, default 16: maximum DMA beats per grant, ≥1.
- `STARVE_LIMIT`, default 8: blocked DMA-request cycles before a forced grant, ≥1.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `core_addr_i` in ADDR_W: core data address.
- `core_wdata_i` in DATA_W: core write data.
- `core_we_i` in 1: core write request.
- `core_re_i` in 1: core read request.
- `core_size_i` in 3: core access size.
- `core_rdata_o` out DATA_W: read data to the core's MEM stage.
- `core_hold_o` out 1: stall request to the core.
- `dma_req_i` in 1: DMA request/beat valid.
- `dma_addr_i` in ADDR_W: DMA beat address.
- `dma_wdata_i` in DATA_W: DMA write data.
- `dma_we_i` in 1: 1 = write beat, 0 = read beat.
- `dma_size_i` in 3: DMA access size.
- `dma_last_i` in 1: final beat of the burst.
- `dma_gnt_o` out 1: DMA owns the port.
- `dma_rdata_o` out DATA_W: DMA read data.
- `dma_rvalid_o` out 1: `dma_rdata_o` is valid.
- `ram_addr_o` out ADDR_W: RAM address.
- `ram_wdata_o` out DATA_W: RAM write data.
- `ram_we_o` out 1: RAM write enable.
- `ram_re_o` out 1: RAM read enable.
- `ram_size_o` out 3: RAM access size.
- `ram_rdata_i` in DATA_W: RAM read data, valid one cycle after `ram_re_o`.

## Operation
- **Core access:** `core_we_i | core_re_i`. Both asserted together is treated as a write.
- **DMA beat:** a cycle with `dma_gnt_o && dma_req_i`.
- **States:**
  - `S_CORE`: the core owns the port. RAM outputs are a combinational pass-through of the core inputs. `dma_gnt_o` = 0, `core_hold_o` = 0.
  - `S_DMA`: `dma_gnt_o` = 1 and the RAM outputs are driven by the DMA inputs. `ram_we_o = dma_req_i & dma_we_i` and `ram_re_o = dma_req_i & ~dma_we_i`. `core_hold_o` = core access. Core inputs are ignored.
  - `S_COOL`: one cycle of guaranteed core ownership, with the same outputs as `S_CORE`.
- **Transitions:**
  - `S_CORE`→`S_DMA` when `dma_req_i && (!core access || starve_cnt == STARVE_LIMIT)`.
  - `S_DMA`→`S_COOL` on any of:
    - a beat with `dma_last_i`;
    - the beat that brings `beat_cnt` to `MAX_BURST`;
    - a cycle in `S_DMA` with `dma_req_i` = 0 (no beat occurs).
  - `S_COOL`→`S_CORE` unconditionally.
- **starve_cnt:**
  - Increments, saturating at `STARVE_LIMIT`, on each `S_CORE` cycle with `dma_req_i` and a core access.
  - Clears on entry to `S_DMA`, and in any `S_CORE` cycle with `dma_req_i` = 0.
- **beat_cnt:** width $clog2(MAX_BURST+1); clears on entry to `S_DMA`; increments per beat.
- **Read return:**
  - `core_rdata_o = ram_rdata_i` at all times. The core consumes it only for its own reads.
  - `dma_rvalid_o` is registered: 1 in the cycle after a DMA read beat, else 0.
  - `dma_rdata_o = ram_rdata_i`, meaningful only when `dma_rvalid_o` = 1.
- **Core hold:** a core access held in `S_DMA` stays stable on the inputs. It is issued on the first `S_COOL` or `S_CORE` cycle.

## Timing
- **Reset (`rst` = 0):**
  - Asynchronously: state `S_CORE`, `starve_cnt` = 0, `beat_cnt` = 0, `dma_rvalid_o` = 0.
  - Hence `dma_gnt_o` = 0 and `core_hold_o` = 0.
  - RAM outputs mirror the core inputs.
  - Reset mid-burst aborts the burst immediately; no further RAM strobes come from the DMA side.
- **Core path:** zero-cycle combinational latency in `S_CORE`/`S_COOL`.
- **Request to grant:** minimum 1 cycle (`dma_req_i` sampled at edge N, `dma_gnt_o` high in cycle N+1).
- **DMA write:** committed at the edge ending the beat cycle.
- **DMA read:** data valid exactly 1 cycle after the beat.
- **Grant gap:** at least one `S_COOL` cycle separates consecutive grants.
- **Forced grant:** under continuous core accesses, `dma_gnt_o` rises `STARVE_LIMIT`+1 cycles after `dma_req_i` first asserts.
- **Simultaneous events:** core access and `dma_req_i` in `S_CORE` with `starve_cnt` < `STARVE_LIMIT` → the core is served.
- **Last beat at the limit:** `dma_last_i` together with `beat_cnt` reaching `MAX_BURST` → a single transition to `S_COOL`.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - The starvation counter is present.
  - A forced grant occurs as described in Operation.
- `ARB_STARVE_GUARD_EN` undefined:
  - `starve_cnt` is not built.
  - `S_CORE`→`S_DMA` only when `dma_req_i && !core access`.
  - The DMA master can starve indefinitely.

## Test plan
- **Reset:** drive `rst` = 0 for 3 cycles with `dma_req_i` = 1 → `dma_gnt_o` = 0, `core_hold_o` = 0, `dma_rvalid_o` = 0. `ram_addr_o` tracks `core_addr_i` = 0x40.
- **DMA write burst:**
  - Stimulus: core idle; DMA write burst of 4 beats to 0x100, 0x104, 0x108, 0x10C, `dma_last_i` on beat 4.
  - Required: `dma_gnt_o` high 1 cycle after request; exactly 4 `ram_we_o` pulses with matching addresses; then 1 `S_COOL` cycle with `dma_gnt_o` = 0.
- **Starvation:**
  - Stimulus: `STARVE_LIMIT` = 8; core reads every cycle; `dma_req_i` held.
  - With macro: `dma_gnt_o` rises on cycle 9; `core_hold_o` = 1 throughout the burst; the held core read reaches `ram_re_o` on the `S_COOL` cycle.
  - Without macro: `dma_gnt_o` never rises.
- **Burst cap:** `MAX_BURST` = 16, `dma_last_i` never asserted → exactly 16 beats, `dma_gnt_o` drops, regrant no earlier than 2 cycles later.
- **DMA read:** DMA read at 0x200 with `ram_rdata_i` = 0xDEADBEEF → `dma_rvalid_o` = 1 with `dma_rdata_o` = 0xDEADBEEF in the next cycle only.
- **Reset mid-burst:** assert `rst` = 0 asynchronously on beat 3 of 8 → `dma_gnt_o`, `core_hold_o` and `dma_rvalid_o` = 0 before the next edge. After release, a fresh burst starts with `beat_cnt` = 0.
